// File: rtl/ahb_arb_pkg.sv
// Shared response/state encodings and index helper for the AHB bus arbiter.
package ahb_arb_pkg;

    typedef enum logic [1:0] {
        OKAY  = 2'b00,
        ERROR = 2'b01,
        RETRY = 2'b10,
        SPLIT = 2'b11
    } hresp_e;

    typedef enum logic [1:0] {
        DEFAULT = 2'b00,
        GRANTED = 2'b01,
        LOCKED  = 2'b10
    } arb_state_e;

    // OR-encoding is exact for a one-hot input and yields 0 for an all-zero input.
    function automatic logic [3:0] onehot2idx(input logic [15:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) idx = idx | 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ahb_arb_pick.sv
// Combinational request picker: rotating priority from a start index, or lowest
// index first when rotation is disabled.
module ahb_arb_pick
    import ahb_arb_pkg::*;
#(
    parameter  int N  = 16,
    localparam int SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] start,
    input  logic          rr_mode,
    output logic [N-1:0]  gnt,
    output logic          valid
);

    localparam logic [N-1:0] ONE = N'(1);

    logic [SW-1:0] s;
    logic [N-1:0]  rot;
    logic [N-1:0]  lsb;

    // Rotate so the start index sits at bit 0, isolate the lowest set bit,
    // then rotate the single bit back into place.
    always_comb begin
        s     = rr_mode ? start : '0;
        rot   = N'({req, req} >> s);
        lsb   = rot & (~rot + ONE);
        gnt   = N'(({lsb, lsb} << s) >> N);
        valid = |req;
    end

endmodule

// File: rtl/ahb_arbiter_rr.sv
// AHB-Lite/AHB2 bus arbiter: round-robin or fixed priority, bounded tenure,
// locked transfers and SPLIT parking with HSPLIT release.
//
// state   | meaning
// DEFAULT | no eligible request, default master parked on the bus
// GRANTED | unlocked owner, tenure bounded by hold_cnt
// LOCKED  | owner asserting HLOCKx, kept until lock drops or it is split
module ahb_arbiter_rr
    import ahb_arb_pkg::*;
#(
    parameter  int NUM_MASTERS    = 16,
    parameter  int DEFAULT_MASTER = 0,
    parameter  int RR_MODE        = 1,
    parameter  int MAX_HOLD       = 16,
    localparam int MW             = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic [NUM_MASTERS-1:0] HBUSREQx,
    input  logic [NUM_MASTERS-1:0] HLOCKx,
    input  logic [NUM_MASTERS-1:0] HSPLIT,
    input  logic                   HREADY,
    input  logic [1:0]             HRESP,
    output logic [NUM_MASTERS-1:0] HGRANTx,
    output logic [MW-1:0]          HMASTER,
    output logic                   HMASTLOCK,
    output logic [NUM_MASTERS-1:0] split_mask
);

    localparam int                     HW       = $clog2(MAX_HOLD) + 1;
    localparam logic [NUM_MASTERS-1:0] ONE      = NUM_MASTERS'(1);
    localparam logic [NUM_MASTERS-1:0] DEF_OH   = ONE << DEFAULT_MASTER;
    localparam logic [MW-1:0]          DEF_IDX  = MW'(DEFAULT_MASTER);
    localparam logic [MW-1:0]          LAST_IDX = MW'(NUM_MASTERS - 1);
    localparam logic [HW-1:0]          HOLD_LIM = HW'(MAX_HOLD - 1);

    arb_state_e             state, nxt_state;
    logic [HW-1:0]          hold_cnt, nxt_hold;
    logic [MW-1:0]          rr_ptr, nxt_rr, rr_next;
    logic                   split_pend;
    logic [NUM_MASTERS-1:0] nxt_grant;
    logic [NUM_MASTERS-1:0] elig, others, split_set;
    logic [NUM_MASTERS-1:0] pick_gnt;
    logic                   pick_valid;
    logic [15:0]            grant16, pick16;
    logic [3:0]             g_idx_full, pick_idx_full;
    logic [MW-1:0]          g_idx, pick_idx;
    logic                   own_req, own_lock, own_masked, split_evt;

    ahb_arb_pick #(.N(NUM_MASTERS)) u_pick (
        .req     (elig),
        .start   (rr_next),
        .rr_mode (RR_MODE != 0),
        .gnt     (pick_gnt),
        .valid   (pick_valid)
    );

    always_comb begin
        grant16                 = '0;
        grant16[NUM_MASTERS-1:0] = HGRANTx;
        pick16                  = '0;
        pick16[NUM_MASTERS-1:0]  = pick_gnt;
        g_idx_full              = onehot2idx(grant16);
        pick_idx_full           = onehot2idx(pick16);
        g_idx                   = g_idx_full[MW-1:0];
        pick_idx                = pick_idx_full[MW-1:0];
        rr_next                 = (rr_ptr == LAST_IDX) ? '0 : rr_ptr + MW'(1);

        elig       = HBUSREQx & ~split_mask;
        others     = elig & ~HGRANTx;
        own_req    = |(HBUSREQx & HGRANTx);
        own_lock   = |(HLOCKx & HGRANTx);
        own_masked = |(split_mask & HGRANTx);
        split_evt  = (HRESP == SPLIT) && !HREADY;
        split_set  = split_evt ? (ONE << HMASTER) : '0;
    end

    // A pending split skips both keep rules so the parked master is dropped
    // even while it holds a lock.
    always_comb begin
        nxt_grant = HGRANTx;
        nxt_state = state;
        nxt_hold  = hold_cnt;
        nxt_rr    = rr_ptr;
        if (!split_pend && own_lock && !own_masked) begin
            nxt_state = LOCKED;
        end else if (!split_pend && state == GRANTED && own_req && !own_masked &&
                     (hold_cnt < HOLD_LIM || others == '0)) begin
            nxt_state = GRANTED;
            if (hold_cnt < HOLD_LIM) nxt_hold = hold_cnt + HW'(1);
        end else if (pick_valid) begin
            nxt_grant = pick_gnt;
            nxt_state = GRANTED;
            nxt_hold  = '0;
            nxt_rr    = pick_idx;
        end else begin
            nxt_grant = DEF_OH;
            nxt_state = DEFAULT;
            nxt_hold  = '0;
            nxt_rr    = DEF_IDX;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            HGRANTx    <= DEF_OH;
            HMASTER    <= DEF_IDX;
            HMASTLOCK  <= 1'b0;
            split_mask <= '0;
            hold_cnt   <= '0;
            rr_ptr     <= DEF_IDX;
            state      <= DEFAULT;
            split_pend <= 1'b0;
        end else begin
            split_mask <= (split_mask & ~HSPLIT) | split_set;
            if (HREADY) begin
                HGRANTx    <= nxt_grant;
                HMASTER    <= g_idx;
                HMASTLOCK  <= own_lock;
                hold_cnt   <= nxt_hold;
                rr_ptr     <= nxt_rr;
                state      <= nxt_state;
                split_pend <= 1'b0;
            end else if (split_evt) begin
                split_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ahb_arbiter_rr.sv
// Bench for ahb_arbiter_rr: a round-robin and a fixed-priority instance share
// stimulus and are compared every cycle against an index-level reference model.
module tb_ahb_arbiter_rr;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [15:0] hbusreq, hlock, hsplit;
    logic        HREADY;
    logic [1:0]  HRESP;

    logic [15:0] rr_grant;
    logic [3:0]  rr_master;
    logic        rr_lock;
    logic [15:0] rr_mask;
    logic [7:0]  fp_grant;
    logic [2:0]  fp_master;
    logic        fp_lock;
    logic [7:0]  fp_mask;

    always #5 HCLK = ~HCLK;

    ahb_arbiter_rr #(.NUM_MASTERS(16), .DEFAULT_MASTER(0), .RR_MODE(1), .MAX_HOLD(2)) u_rr (
        .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQx(hbusreq), .HLOCKx(hlock),
        .HSPLIT(hsplit), .HREADY(HREADY), .HRESP(HRESP), .HGRANTx(rr_grant),
        .HMASTER(rr_master), .HMASTLOCK(rr_lock), .split_mask(rr_mask)
    );

    ahb_arbiter_rr #(.NUM_MASTERS(8), .DEFAULT_MASTER(2), .RR_MODE(0), .MAX_HOLD(3)) u_fp (
        .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQx(hbusreq[7:0]), .HLOCKx(hlock[7:0]),
        .HSPLIT(hsplit[7:0]), .HREADY(HREADY), .HRESP(HRESP), .HGRANTx(fp_grant),
        .HMASTER(fp_master), .HMASTLOCK(fp_lock), .split_mask(fp_mask)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Per-instance configuration: [0] = u_rr, [1] = u_fp.
    int p_n[2]   = '{16, 8};
    int p_def[2] = '{0, 2};
    int p_rr[2]  = '{1, 0};
    int p_mh[2]  = '{2, 3};

    // Model: owner as an integer, mode 0=idle/default, 1=normal, 2=locked.
    int          m_grant[2], m_master[2], m_mode[2], m_hold[2], m_ptr[2];
    bit          m_lock[2], m_pend[2];
    logic [15:0] m_mask[2];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input int u);
        int          n, g, found, c;
        bit          lk, mg, others, split_evt;
        logic [15:0] nmask;
        n = p_n[u];
        if (!HRESETn) begin
            m_grant[u]  = p_def[u];
            m_master[u] = p_def[u];
            m_lock[u]   = 1'b0;
            m_mask[u]   = '0;
            m_hold[u]   = 0;
            m_ptr[u]    = p_def[u];
            m_mode[u]   = 0;
            m_pend[u]   = 1'b0;
            return;
        end
        split_evt = (HRESP == 2'b11) && !HREADY;
        nmask = m_mask[u] & ~hsplit;
        if (split_evt) nmask[m_master[u]] = 1'b1;
        if (HREADY) begin
            g      = m_grant[u];
            lk     = hlock[g];
            mg     = m_mask[u][g];
            others = 1'b0;
            for (int i = 0; i < n; i++)
                if (i != g && hbusreq[i] && !m_mask[u][i]) others = 1'b1;
            if (!m_pend[u] && lk && !mg) begin
                m_mode[u] = 2;
            end else if (!m_pend[u] && m_mode[u] == 1 && hbusreq[g] && !mg &&
                         (m_hold[u] < p_mh[u] - 1 || !others)) begin
                if (m_hold[u] < p_mh[u] - 1) m_hold[u]++;
            end else begin
                found = -1;
                for (int k = 0; k < n; k++) begin
                    c = (p_rr[u] != 0) ? (m_ptr[u] + 1 + k) % n : k;
                    if (found < 0 && hbusreq[c] && !m_mask[u][c]) found = c;
                end
                if (found >= 0) begin
                    m_grant[u] = found;
                    m_mode[u]  = 1;
                end else begin
                    m_grant[u] = p_def[u];
                    m_mode[u]  = 0;
                end
                m_hold[u] = 0;
                m_ptr[u]  = m_grant[u];
            end
            m_master[u] = g;
            m_lock[u]   = lk;
            m_pend[u]   = 1'b0;
        end
        if (split_evt) m_pend[u] = 1'b1;
        m_mask[u] = nmask;
    endtask

    task automatic check_all();
        chk_eq("rr_grant",     32'(rr_grant),          32'(1) << m_grant[0]);
        chk_eq("rr_master",    32'(rr_master),         32'(m_master[0]));
        chk_eq("rr_mastlock",  32'(rr_lock),           32'(m_lock[0]));
        chk_eq("rr_splitmask", 32'(rr_mask),           32'(m_mask[0]));
        chk_eq("rr_onehot",    32'($onehot(rr_grant)), 32'd1);
        chk_eq("fp_grant",     32'(fp_grant),          32'(1) << m_grant[1]);
        chk_eq("fp_master",    32'(fp_master),         32'(m_master[1]));
        chk_eq("fp_mastlock",  32'(fp_lock),           32'(m_lock[1]));
        chk_eq("fp_splitmask", 32'(fp_mask),           32'(m_mask[1]));
        chk_eq("fp_onehot",    32'($onehot(fp_grant)), 32'd1);
    endtask

    task automatic tick();
        model_step(0);
        model_step(1);
        @(posedge HCLK);
        @(negedge HCLK);
        check_all();
    endtask

    int exp_g[7] = '{1, 1, 2, 2, 3, 3, 1};
    int exp_m[7] = '{0, 1, 1, 2, 2, 3, 3};

    initial begin
        HRESETn = 1'b0; hbusreq = '0; hlock = '0; hsplit = '0;
        HREADY  = 1'b1; HRESP   = 2'b00;

        // Reset held over several edges.
        repeat (3) begin
            tick();
            chk_eq("rst_grant",    32'(rr_grant),  32'h0001);
            chk_eq("rst_master",   32'(rr_master), 32'd0);
            chk_eq("rst_mastlock", 32'(rr_lock),   32'd0);
        end

        // Round-robin rotation with a two-cycle tenure.
        HRESETn = 1'b1; hbusreq = 16'h000E;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk_eq("rr_seq_grant",  32'(rr_grant),  32'(1) << exp_g[i]);
            chk_eq("rr_seq_master", 32'(rr_master), 32'(exp_m[i]));
        end

        // Fixed priority handover across an HREADY stall.
        HRESETn = 1'b0; tick(); HRESETn = 1'b1;
        hbusreq = 16'h0030; tick();
        chk_eq("fp_first", 32'(fp_grant), 32'h10);
        hbusreq = 16'h0020; HREADY = 1'b0;
        repeat (3) begin
            tick();
            chk_eq("fp_stall_grant",  32'(fp_grant),  32'h10);
            chk_eq("fp_stall_master", 32'(fp_master), 32'd2);
        end
        HREADY = 1'b1; tick();
        chk_eq("fp_handover", 32'(fp_grant), 32'h20);
        tick();
        chk_eq("fp_master5", 32'(fp_master), 32'd5);

        // SPLIT parking, release, and set-beats-clear.
        HRESETn = 1'b0; tick(); HRESETn = 1'b1;
        hbusreq = 16'h0008; repeat (3) tick();
        HREADY = 1'b0; HRESP = 2'b11; tick();
        chk_eq("split_set", 32'(rr_mask), 32'h0008);
        HREADY = 1'b1; HRESP = 2'b00; tick();
        chk_eq("split_regrant", 32'(rr_grant), 32'h0001);
        hsplit = 16'h0008; tick();
        chk_eq("split_clear", 32'(rr_mask), 32'h0000);
        hsplit = '0; tick();
        chk_eq("split_back", 32'(rr_grant), 32'h0008);
        tick();
        HREADY = 1'b0; HRESP = 2'b11; hsplit = 16'h0008; tick();
        chk_eq("split_set_wins", 32'(rr_mask), 32'h0008);

        // Locked burst, then reset in the middle of it.
        HREADY = 1'b1; HRESP = 2'b00; hsplit = '0;
        hbusreq = 16'h0006; hlock = 16'h0004;
        repeat (10) tick();
        chk_eq("lock_grant",    32'(rr_grant), 32'h0004);
        chk_eq("lock_mastlock", 32'(rr_lock),  32'd1);
        HRESETn = 1'b0; tick();
        chk_eq("midrst_grant", 32'(rr_grant), 32'h0001);
        chk_eq("midrst_lock",  32'(rr_lock),  32'd0);
        chk_eq("midrst_mask",  32'(rr_mask),  32'h0000);
        HRESETn = 1'b1; repeat (5) tick();
        hlock = '0; tick();
        chk_eq("unlock_move", 32'(rr_grant), 32'h0002);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            HRESETn = ($urandom_range(0, 99) != 0);
            hbusreq = 16'($urandom) & 16'($urandom);
            if ($urandom_range(0, 3) == 0) hbusreq = 16'($urandom);
            hlock   = ($urandom_range(0, 2) == 0) ? (16'($urandom) & hbusreq) : 16'h0000;
            HREADY  = ($urandom_range(0, 3) != 0);
            if (!HREADY && $urandom_range(0, 5) == 0) HRESP = 2'b11;
            else HRESP = 2'($urandom_range(0, 3));
            hsplit  = ($urandom_range(0, 5) == 0) ? (16'h0001 << $urandom_range(0, 15)) : 16'h0000;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_arbiter_rr.md
Name: ahb_arbiter_rr

Overview:
Parametrised AHB-Lite/AHB2 bus arbiter for up to NUM_MASTERS masters. It supports two modes, round-robin or fixed priority. It also provides:
- bounded bus tenure via a hold counter;
- locked transfers;
- SPLIT masking with HSPLIT release.
It sits between the master request lines and the address/data mux control (HMASTER, HMASTLOCK), and replaces the fixed 16-master arbiter.

Parameters:
NUM_MASTERS, 16, number of masters (2..16).
DEFAULT_MASTER, 0, master granted when no eligible request exists.
RR_MODE, 1, 1 = round-robin, 0 = fixed priority (lowest index wins).
MAX_HOLD, 16, HREADY-qualified cycles an unlocked owner may keep the bus while others wait (>=1).

Ports:
HCLK  in  1  clock, rising edge.
HRESETn  in  1  reset, synchronous, active-low.
HBUSREQx  in  NUM_MASTERS  bus request per master.
HLOCKx  in  NUM_MASTERS  locked-transfer request per master.
HSPLIT  in  NUM_MASTERS  slave split-release; pulse on bit i unmasks master i.
HREADY  in  1  transfer complete / arbitration enable.
HRESP  in  2  slave response (OKAY/ERROR/RETRY/SPLIT).
HGRANTx  out  NUM_MASTERS  registered one-hot grant.
HMASTER  out  MW=max(1,$clog2(NUM_MASTERS))  registered index of address-phase owner.
HMASTLOCK  out  1  registered; current address phase is locked.
split_mask  out  NUM_MASTERS  registered; masters currently parked by SPLIT.

Behaviour:
- Reset (HRESETn=0 at a rising edge, including mid-transfer):
  - HGRANTx=1<<DEFAULT_MASTER, HMASTER=DEFAULT_MASTER, HMASTLOCK=0.
  - split_mask=0, hold_cnt=0, rr_ptr=DEFAULT_MASTER, state=DEFAULT.
- Invariant: HGRANTx is exactly one-hot every cycle after reset, never zero.
- Eligible set: E = HBUSREQx & ~split_mask.
- Arbitration occurs only on edges where HREADY=1. With HREADY=0, HGRANTx, HMASTER, HMASTLOCK and hold_cnt hold.
- Handover: on an HREADY=1 edge, HMASTER <= index(HGRANTx) and HMASTLOCK <= HLOCKx[index(HGRANTx)], both taken from pre-edge values. A grant change therefore reaches HMASTER one HREADY cycle later.
- States: DEFAULT (no eligible request, default master granted), GRANTED (unlocked owner), LOCKED (owner asserting HLOCKx).
- Next grant on an HREADY=1 edge, with owner g = index(HGRANTx):
  1. LOCKED (HLOCKx[g]=1 and g not masked): keep g; hold_cnt is not incremented.
  2. GRANTED with HBUSREQx[g]=1, hold_cnt<MAX_HOLD-1, or E without bit g empty: keep g and increment hold_cnt.
  3. Otherwise pick from E. With RR_MODE=1, search from (rr_ptr+1) mod NUM_MASTERS upward with wrap. With RR_MODE=0, take the lowest set index.
  4. E empty: grant DEFAULT_MASTER and go to DEFAULT.
- On any grant change: hold_cnt<=0 and rr_ptr<=new owner.
- Picker: a grant to an index >= NUM_MASTERS is impossible.
- Split:
  - When HRESP=SPLIT and HREADY=0 (first response cycle), set split_mask[HMASTER].
  - The same edge forces rearbitration at the next HREADY=1, with the split master excluded even if locked. The lock is dropped and the state leaves LOCKED.
  - HSPLIT[i]=1 clears split_mask[i].
  - Set and clear on the same bit in the same cycle: set wins.
- RETRY and ERROR do not affect arbitration.
- A masked DEFAULT_MASTER is still granted as the fallback (dummy-master role). Its request is ignored until it is unmasked.

Decomposition:
- ahb_arb_pkg holds:
  - hresp_e (OKAY=2'b00, ERROR=2'b01, RETRY=2'b10, SPLIT=2'b11);
  - arb_state_e (DEFAULT, GRANTED, LOCKED);
  - function onehot2idx.
- One sub-module, ahb_arb_pick: combinational rotating/fixed priority picker with inputs req vector, start pointer and mode, and outputs one-hot plus valid. Instantiated once.
- FSM, hold counter, split mask and output registers live in ahb_arbiter_rr.

Test Plan:
1. Reset with no requests, HREADY=1 → HGRANTx=16'h0001, HMASTER=0, HMASTLOCK=0. Verify values are held while HRESETn=0 over multiple edges.
2. RR_MODE=1, HBUSREQx=16'h000E held, MAX_HOLD=2 → grant sequence 1,1,2,2,3,3,1. HMASTER lags HGRANTx by one HREADY cycle.
3. RR_MODE=0, HBUSREQx=16'h0030, then master 4 drops → grant 4, then 5. With HREADY=0 for 3 cycles during the change, grant and HMASTER hold.
4. Master 2 with HLOCKx[2]=1, HBUSREQx=16'h0006, MAX_HOLD=2, 10 HREADY cycles → grant stays 2 and HMASTLOCK=1 from the second HREADY edge. HLOCKx[2]→0 → grant moves to 1 after at most one further HREADY cycle.
5. Owner 3 gets HRESP=SPLIT (HREADY=0, then 1) → split_mask=16'h0008 and grant moves to the next eligible master, or DEFAULT_MASTER if none. HSPLIT[3] pulse → mask clears and master 3 is granted again. Simultaneous HSPLIT[3] and new SPLIT on 3 → mask stays set.
6. Reset asserted mid-locked-burst → next edge restores all reset values, split_mask=0.
